dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles from accept to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port start, input, 1 bit: asynchronous active-low reset; start low resets, start high runs.
REQ-005 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 store, 0 load.
REQ-008 SHALL have port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port req_unsigned, input, 1 bit: load zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: initiator accepts response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: load result, 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: request was misaligned, out of range or reserved size.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; req_valid=1 captures all req_* fields, loads counter with LATENCY-1, moves to WAIT.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; when counter=0 the access executes at that edge and state moves to RESP.
REQ-019 RESP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1; that edge returns to IDLE.
REQ-020 Accept-to-rsp_valid latency SHALL be exactly LATENCY+1 cycles; no new request accepted in same cycle as response handshake.
REQ-021 Word index SHALL be addr[31:2]; byte lanes little-endian (addr[1:0]=0 is bits 7:0).
REQ-022 Error SHALL be: size=3, size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS.
REQ-023 Erroring store SHALL not modify memory; erroring load SHALL return rsp_rdata=0, rsp_err=1.
REQ-024 Store SHALL write only the addressed byte(s) from req_wdata low bits; other bytes unchanged.
REQ-025 Load SHALL extract addressed byte/half and sign- or zero-extend per captured req_unsigned; word loads ignore req_unsigned.
REQ-026 Changes on req_* after acceptance SHALL not affect the in-flight access.
REQ-027 rsp_valid held with rsp_ready=0 indefinitely SHALL stall without data change.

Reset
REQ-028 start low SHALL asynchronously force state IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 start low SHALL clear all memory words to 0.
REQ-030 Reset mid-WAIT SHALL abort the access: no memory write occurs, no response issued.

Configuration
REQ-031 Macro DMEM_RESPONDER_STATS_EN defined SHALL add outputs rd_count, wr_count, err_count (16 bits each), incrementing on each response handshake by type, saturating at 16'hFFFF, cleared by reset.
REQ-032 Macro undefined SHALL omit these ports and counters; all other behaviour identical.

Verification
REQ-033 Reset, store word 32'hDEADBEEF at 0x10, load word 0x10 -> rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept (LATENCY=2).
REQ-034 Store byte 8'h80 at 0x13 over above, load signed byte 0x13 -> 32'hFFFFFF80; unsigned -> 32'h00000080; load word 0x10 -> 32'h80ADBEEF.
REQ-035 Load half at 0x11 -> rsp_err=1, rsp_rdata=0; store word at DEPTH_WORDS*4 -> rsp_err=1, memory unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0; then rsp_ready=1 -> IDLE next cycle.
REQ-037 Accept store word 0x20, drop start during WAIT -> load 0x20 after release returns 0, no spurious rsp_valid.
REQ-038 With DMEM_RESPONDER_STATS_EN: 2 loads, 1 store, 1 error -> rd_count=2, wr_count=1, err_count=1.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready request and
// response handshake with a programmable access latency.
// Optional build macro DMEM_RESPONDER_STATS_EN adds saturating response
// counters rd_count, wr_count and err_count.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            capture, exec;

  logic            write_q, unsigned_q;
  logic [1:0]      size_q;
  logic [31:0]     addr_q, wdata_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            in_range, err;
  logic [1:0]      off;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wr_sh, rd_word, rd_sh, ld_data;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
    end
  end

  // Access decode from the captured request.
  always_comb begin
    off      = addr_q[1:0];
    idx      = addr_q[AW+1:2];
    in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    err      = (size_q == 2'd3) ||
               ((size_q == 2'd1) && addr_q[0]) ||
               ((size_q == 2'd2) && (off != 2'd0)) ||
               !in_range;
    case (size_q)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    wr_sh   = wdata_q << {off, 3'b000};
    rd_word = in_range ? mem[idx] : 32'd0;
    rd_sh   = rd_word >> {off, 3'b000};
    case (size_q)
      2'd0:    ld_data = unsigned_q ? {24'd0, rd_sh[7:0]}
                                    : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    ld_data = unsigned_q ? {16'd0, rd_sh[15:0]}
                                    : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  // Request capture, memory array and response data.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
    end else begin
      if (capture) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (exec) begin
        rsp_err   <= err;
        rsp_rdata <= (err || write_q) ? 32'd0 : ld_data;
        if (!err && write_q) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wr_sh[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  logic hs;
  assign hs = (state_q == RESP) && rsp_ready;

  // Saturating per-type counters bumped on each response handshake.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (hs) begin
      if (rsp_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (write_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        start;
  logic        req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
`endif

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble req_* after acceptance, collect response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin tick(); n++; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~uns;
    req_addr = ~a; req_wdata = ~wd;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    rd = rsp_rdata; er = rsp_err;
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=0 want 1", a);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", rsp_err); end
    start = 1'b1;
    tick();
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL st_word got err=%b rd=%h want 0/0", er, rd); end
    checks++; if (lat != LAT + 1) begin failures++; $display("FAIL st_latency got %0d want %0d", lat, LAT + 1); end
    do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_word got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_word_err got %b want 0", er); end
    checks++; if (lat != LAT + 1) begin failures++; $display("FAIL ld_latency got %0d want %0d", lat, LAT + 1); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_after_hs got %b want 1", req_ready); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'd0, 0, 32'h13, 32'hFFFFFF80, rd, er, lat);
    do_req(0, 2'd0, 0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL ld_byte_s got %h want ffffff80", rd); end
    do_req(0, 2'd0, 1, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL ld_byte_u got %h want 00000080", rd); end
    do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin failures++; $display("FAIL ld_word_merge got %h want 80adbeef", rd); end
    do_req(0, 2'd1, 0, 32'h12, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF80AD) begin failures++; $display("FAIL ld_half_s got %h want ffff80ad", rd); end
    do_req(0, 2'd1, 1, 32'h12, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000080AD) begin failures++; $display("FAIL ld_half_u got %h want 000080ad", rd); end
    do_req(1, 2'd1, 0, 32'h10, 32'hAAAA1234, rd, er, lat);
    do_req(0, 2'd2, 1, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80AD1234) begin failures++; $display("FAIL st_half_merge got %h want 80ad1234", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 2'd1, 0, 32'h11, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL err_half_misalign got err=%b rd=%h want 1/0", er, rd); end
    do_req(1, 2'd2, 0, DEPTH * 4, 32'h55555555, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_range got %b want 1", er); end
    do_req(0, 2'd2, 0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL range_no_wrap got rd=%h err=%b want 0/0", rd, er); end
    do_req(1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_word_misalign got %b want 1", er); end
    do_req(1, 2'd3, 0, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_size3 got %b want 1", er); end
    do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80AD1234) begin failures++; $display("FAIL err_no_write got %h want 80ad1234", rd); end
    do_req(0, 2'd2, 0, 32'h3FC, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_ok got %b want 0", er); end
  endtask

  task automatic test_stall();
    int n;
    req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10;
    tick();
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AD1234 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h e=%b rdy=%b want 1/80ad1234/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    bit spurious;
    req_valid = 1; req_write = 1; req_size = 2'd2; req_unsigned = 0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    tick();
    req_valid = 0;
    start = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got %b want 0", rsp_valid); end
    tick();
    start = 1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid) spurious = 1; end
    checks++; if (spurious) begin failures++; $display("FAIL abort_spurious got rsp_valid=1 want 0"); end
    do_req(0, 2'd2, 0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL abort_no_write got rd=%h err=%b want 0/0", rd, er); end
    do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_clears_mem got %h want 0", rd); end
  endtask

`ifdef DMEM_RESPONDER_STATS_EN
  task automatic test_stats();
    logic [31:0] rd; logic er; int lat;
    start = 0; tick(); start = 1; tick();
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 16'd0) begin
      failures++; $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", rd_count, wr_count, err_count);
    end
    do_req(1, 2'd2, 0, 32'h4, 32'h1, rd, er, lat);
    do_req(0, 2'd2, 0, 32'h4, 32'h0, rd, er, lat);
    do_req(0, 2'd0, 1, 32'h5, 32'h0, rd, er, lat);
    do_req(0, 2'd1, 0, 32'h1, 32'h0, rd, er, lat);
    checks++; if (rd_count !== 16'd2 || wr_count !== 16'd1 || err_count !== 16'd1) begin
      failures++; $display("FAIL stats_counts got %0d/%0d/%0d want 2/1/1", rd_count, wr_count, err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid_wait();
`ifdef DMEM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
